// File: rtl/seg_disp_sched_pkg.sv
// seg_disp_sched_pkg: shared state encodings, sizes and source-index helpers
package seg_disp_sched_pkg;
    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 2;

    typedef enum logic {S_AUTO = 1'b0, S_MANUAL = 1'b1} state_t;

    // first index set in mask searched round-robin after cur; cur itself if none
    function automatic logic [SRC_W-1:0] rr_next(input logic [SRC_W-1:0] cur, input logic [NUM_SRC-1:0] mask);
        logic [SRC_W-1:0] idx;
        rr_next = cur;
        for (int k = NUM_SRC - 1; k >= 1; k--) begin
            idx = cur + SRC_W'(k);
            if (mask[idx]) rr_next = idx;
        end
    endfunction

    // lowest set index of mask, 0 when mask is empty
    function automatic logic [SRC_W-1:0] first_set(input logic [NUM_SRC-1:0] mask);
        first_set = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (mask[k]) first_set = SRC_W'(k);
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] i);
        onehot = NUM_SRC'(1) << i;
    endfunction
endpackage

// File: rtl/seg_disp_sched_btn_debounce.sv
// seg_disp_sched_btn_debounce: synchronises a raw button, accepts a level after a stable run, flags its rising edge
module seg_disp_sched_btn_debounce #(
    parameter int               DEB_W      = 20,
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    logic             sync1, sync2, level, level_q;
    logic [DEB_W-1:0] cnt;

    // two-flop sync, then count consecutive samples that differ from the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) cnt <= '0;
            else if (cnt == DEB_CYCLES - DEB_W'(1)) begin
                level <= sync2;
                cnt   <= '0;
            end else cnt <= cnt + DEB_W'(1);
        end
    end

    assign press = level & ~level_q;
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: picks which of four status words drives the 7-seg display (auto rotation or manual stepping)
module seg_disp_sched
    import seg_disp_sched_pkg::*;
#(
    parameter int                 CNT_W        = 24,
    parameter logic [CNT_W-1:0]   DWELL_CYCLES = 24'd12_000_000,
    parameter int                 DEB_W        = 20,
    parameter logic [DEB_W-1:0]   DEB_CYCLES   = 20'd500_000,
    parameter logic [NUM_SRC-1:0] SRC_EN       = 4'b1111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        hex0,
    input  logic [15:0]        hex1,
    input  logic [15:0]        hex2,
    input  logic [15:0]        hex3,
    input  logic [NUM_SRC-1:0] upd,
    input  logic               btn_mode,
    input  logic               btn_next,
    output logic [15:0]        hex_out,
    output logic [SRC_W-1:0]   src_sel,
    output logic               mode_auto,
    output logic [NUM_SRC-1:0] pending
);
    localparam logic [SRC_W-1:0] SEL_RST = first_set(SRC_EN);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               mode_press, next_press, dwell_done;
    logic [NUM_SRC-1:0] pend_en;
    logic [SRC_W-1:0]   auto_next, man_next, sel_d;
    logic [15:0]        hex_sel;

    seg_disp_sched_btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .reset(reset), .btn(btn_mode), .press(mode_press)
    );

    seg_disp_sched_btn_debounce #(.DEB_W(DEB_W), .DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk(clk), .reset(reset), .btn(btn_next), .press(next_press)
    );

    // next source: pending sources jump the queue in auto; a mode press freezes the selection
    always_comb begin
        dwell_done = cnt == DWELL_CYCLES - CNT_W'(1);
        pend_en    = pending & SRC_EN;
        auto_next  = |pend_en ? rr_next(src_sel, pend_en) : rr_next(src_sel, SRC_EN);
        man_next   = rr_next(src_sel, SRC_EN);
        sel_d      = mode_press ? src_sel :
                     state == S_AUTO ? (dwell_done ? auto_next : src_sel) :
                     (next_press ? man_next : src_sel);
        hex_sel    = src_sel[1] ? (src_sel[0] ? hex3 : hex2) : (src_sel[0] ? hex1 : hex0);
    end

    // mode FSM, dwell counter, selection, update flags and registered display word
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_AUTO;
            cnt     <= '0;
            src_sel <= SEL_RST;
            pending <= '0;
            hex_out <= '0;
        end else begin
            src_sel <= sel_d;
            hex_out <= hex_sel;
            pending <= (pending | (upd & SRC_EN & ~onehot(src_sel))) & ~onehot(sel_d);
            if (mode_press) begin
                state <= state == S_AUTO ? S_MANUAL : S_AUTO;
                cnt   <= '0;
            end else if (state == S_AUTO) cnt <= dwell_done ? '0 : cnt + CNT_W'(1);
        end
    end

    assign mode_auto = state == S_AUTO;
endmodule
